// File: rtl/timer_seq_pkg.sv
// Shared definitions for the timer sequencer: command and state encodings,
// default widths and a small state helper.
package timer_seq_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_PRESC_W = 4;

    typedef enum logic [1:0] {
        OP_START  = 2'd0,
        OP_STOP   = 2'd1,
        OP_PAUSE  = 2'd2,
        OP_RESUME = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    // A sequence is in progress whenever the timer is running or paused.
    function automatic logic is_active(input state_e s);
        return (s == ST_RUN) || (s == ST_PAUSE);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Tick divider for the timer sequencer: one tick every presc+1 enabled clocks.
// The divide value is captured on restart; the phase holds while disabled.
module tick_prescaler
    import timer_seq_pkg::*;
#(
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               restart,
    input  logic               enable,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] div_q, div_d;
    logic [PRESC_W-1:0] cnt_q, cnt_d;

    // Next divide value and phase: restart reloads, enable advances and wraps.
    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q;
        if (restart) begin
            div_d = presc;
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == div_q) ? '0 : cnt_q + PRESC_W'(1);
        end
    end

    assign tick = enable && (cnt_q == div_q);

    // Divider registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            cnt_q <= '0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_sequencer.sv
// Command-driven timer: START/STOP/PAUSE/RESUME over a valid/ready handshake,
// one-shot or periodic terminal count, expire pulse and sticky irq.
// Optional tick prescaler enabled with the macro TIMER_SEQ_PRESCALER_EN;
// without it the count advances on every clock spent running.
module timer_sequencer
    import timer_seq_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [WIDTH-1:0]   cmd_period,
    input  logic               cmd_reload,
`ifdef TIMER_SEQ_PRESCALER_EN
    input  logic [PRESC_W-1:0] presc,
`endif
    input  logic               irq_clr,
    output logic [WIDTH-1:0]   count,
    output logic               busy,
    output logic               expire,
    output logic               irq
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   period_q, period_d;
    logic               reload_q, reload_d;
    logic               expire_q, expire_d;
    logic               irq_q, irq_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               cmd_accept;
    logic               tick;

    assign cmd_accept = cmd_valid && cmd_ready_q;

`ifdef TIMER_SEQ_PRESCALER_EN
    logic start_accept;
    assign start_accept = cmd_accept && (cmd_op == OP_START);

    tick_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_tick_prescaler (
        .clk     (clk),
        .rst     (rst),
        .restart (start_accept),
        .enable  (state_q == ST_RUN),
        .presc   (presc),
        .tick    (tick)
    );
`else
    // Every running clock is a tick; the divider width plays no role here.
    assign tick = (state_q == ST_RUN) && (PRESC_W > 0);
`endif

    // Sequencer next state: an accepted command owns the cycle, otherwise a tick counts.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        period_d    = period_q;
        reload_d    = reload_q;
        expire_d    = 1'b0;
        irq_d       = irq_q;
        cmd_ready_d = !cmd_accept;

        if (irq_clr) begin
            irq_d = 1'b0;
        end

        if (cmd_accept) begin
            case (cmd_op_e'(cmd_op))
                OP_START: begin
                    period_d = cmd_period;
                    reload_d = cmd_reload;
                    count_d  = '0;
                    state_d  = ST_RUN;
                end
                OP_STOP: begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end
                OP_PAUSE: begin
                    if (state_q == ST_RUN) begin
                        state_d = ST_PAUSE;
                    end
                end
                OP_RESUME: begin
                    if (state_q == ST_PAUSE) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else if (tick) begin
            if (count_q == period_q) begin
                // Terminal tick; a set here wins over a simultaneous irq_clr.
                expire_d = 1'b1;
                irq_d    = 1'b1;
                if (reload_q) begin
                    count_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    // Sequencer registers with asynchronous clear to an idle, ready timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            period_q    <= '0;
            reload_q    <= 1'b0;
            expire_q    <= 1'b0;
            irq_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            period_q    <= period_d;
            reload_q    <= reload_d;
            expire_q    <= expire_d;
            irq_q       <= irq_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign count     = count_q;
    assign busy      = is_active(state_q);
    assign expire    = expire_q;
    assign irq       = irq_q;
    assign cmd_ready = cmd_ready_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Self-checking bench for timer_sequencer: directed command scenarios, a
// tick-count model compared every clock, and literal expectations per scenario.
module tb_timer_sequencer;
    import timer_seq_pkg::*;

    localparam int WIDTH   = 8;
    localparam int PRESC_W = 4;

    logic               clk;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [WIDTH-1:0]   cmd_period;
    logic               cmd_reload;
`ifdef TIMER_SEQ_PRESCALER_EN
    logic [PRESC_W-1:0] presc;
`endif
    logic               irq_clr;
    logic [WIDTH-1:0]   count;
    logic               busy;
    logic               expire;
    logic               irq;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    timer_sequencer #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_period (cmd_period),
        .cmd_reload (cmd_reload),
`ifdef TIMER_SEQ_PRESCALER_EN
        .presc      (presc),
`endif
        .irq_clr    (irq_clr),
        .count      (count),
        .busy       (busy),
        .expire     (expire),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The run is described by the number of ticks seen since START; the count
    // is derived from it arithmetically rather than tracked step by step.
    int m_mode = 0;        // 0 idle, 1 running, 2 paused
    int m_ticks = 0;
    int m_period = 0;
    int m_presc = 0;
    int m_runclk = 0;      // running clocks since START, drives the tick cadence
    int m_idle_count = 0;
    bit m_reload = 0;
    bit m_irq = 0;
    bit m_exp = 0;
    bit m_ready = 1;

    function automatic int exp_count();
        if (m_mode == 0) return m_idle_count;
        if (m_reload) return m_ticks % (m_period + 1);
        return m_ticks;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit acc;
        bit tick;
        bit terminal;
        if (rst) begin
            m_mode = 0; m_ticks = 0; m_period = 0; m_presc = 0; m_runclk = 0;
            m_idle_count = 0; m_reload = 0; m_irq = 0; m_exp = 0; m_ready = 1;
        end else begin
            acc  = cmd_valid && m_ready;
            tick = (m_mode == 1) && ((m_runclk % (m_presc + 1)) == m_presc);
            if (m_mode == 1) m_runclk++;
            m_exp = 0;
            if (irq_clr) m_irq = 0;
            if (acc) begin
                case (cmd_op)
                    2'd0: begin
                        m_mode = 1; m_ticks = 0; m_runclk = 0;
                        m_period = int'(cmd_period); m_reload = cmd_reload;
`ifdef TIMER_SEQ_PRESCALER_EN
                        m_presc = int'(presc);
`endif
                    end
                    2'd1: begin m_mode = 0; m_idle_count = 0; end
                    2'd2: if (m_mode == 1) m_mode = 2;
                    default: if (m_mode == 2) m_mode = 1;
                endcase
            end else if (tick) begin
                terminal = (exp_count() == m_period);
                if (terminal) begin
                    m_exp = 1;
                    m_irq = 1;
                    if (!m_reload) begin
                        m_mode = 0;
                        m_idle_count = m_period;
                    end
                end
                m_ticks++;
            end
            m_ready = !acc;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst && cmp_en) begin
            chk("cmp_count", 32'(count), 32'(exp_count()));
            chk("cmp_busy", 32'(busy), 32'(m_mode != 0));
            chk("cmp_expire", 32'(expire), 32'(m_exp));
            chk("cmp_irq", 32'(irq), 32'(m_irq));
            chk("cmp_ready", 32'(cmd_ready), 32'(m_ready));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer a command in the current cycle; returns in the cycle after acceptance.
    task automatic issue(input logic [1:0] op, input int per, input bit rel);
        int w;
        w = 0;
        while (!cmd_ready && w < 8) begin
            step(1);
            w++;
        end
        chk("issue_ready", 32'(cmd_ready), 32'd1);
        cmd_op     = op;
        cmd_period = WIDTH'(per);
        cmd_reload = rel;
        cmd_valid  = 1'b1;
        step(1);
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_count(input int v);
        int n;
        n = 0;
        while (count != WIDTH'(v) && n < 400) begin
            step(1);
            n++;
        end
        chk("wait_count", 32'(count), 32'(v));
    endtask

    task automatic clear_irq();
        irq_clr = 1'b1;
        step(1);
        irq_clr = 1'b0;
        chk("irq_cleared", 32'(irq), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nexp;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_period = '0;
        cmd_reload = 1'b0; irq_clr = 1'b0;
`ifdef TIMER_SEQ_PRESCALER_EN
        presc = '0;
`endif
        #2;
        // Reset state.
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_expire", 32'(expire), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        step(2);
        rst = 1'b0;
        cmp_en = 1'b1;
        step(2);

        // One-shot, period 3: expire on the 4th tick, idle holding 3.
        issue(OP_START, 3, 1'b0);
        chk("os_start_count", 32'(count), 32'd0);
        chk("os_start_busy", 32'(busy), 32'd1);
        chk("os_start_ready", 32'(cmd_ready), 32'd0);
        n = 0;
        while (!expire && n < 20) begin
            step(1);
            n++;
        end
        chk("os_expire_delay", 32'(n), 32'd4);
        chk("os_irq", 32'(irq), 32'd1);
        chk("os_busy", 32'(busy), 32'd0);
        chk("os_count", 32'(count), 32'd3);
        step(1);
        chk("os_expire_single", 32'(expire), 32'd0);
        clear_irq();

        // Periodic, period 2: nine ticks give 0,1,2,0,1,2,0,1,2 and three expires.
        issue(OP_START, 2, 1'b1);
        nexp = 0;
        for (int i = 0; i < 9; i++) begin
            chk("per_seq", 32'(count), 32'(i % 3));
            step(1);
            nexp += int'(expire);
        end
        chk("per_expires", 32'(nexp), 32'd3);
        issue(OP_STOP, 0, 1'b0);
        chk("per_stop_count", 32'(count), 32'd0);
        chk("per_stop_busy", 32'(busy), 32'd0);
        clear_irq();

        // Pause at 5 for ten clocks, then resume to 6.
        issue(OP_START, 20, 1'b1);
        wait_count(5);
        issue(OP_PAUSE, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("pause_hold", 32'(count), 32'd5);
            step(1);
        end
        chk("pause_busy", 32'(busy), 32'd1);
        issue(OP_RESUME, 0, 1'b0);
        chk("resume_count", 32'(count), 32'd5);
        step(1);
        chk("resume_next", 32'(count), 32'd6);
        issue(OP_STOP, 0, 1'b0);

        // STOP on the terminal-count cycle: no expire, count 0, idle.
        issue(OP_START, 3, 1'b0);
        wait_count(3);
        issue(OP_STOP, 0, 1'b0);
        chk("stopterm_expire", 32'(expire), 32'd0);
        chk("stopterm_count", 32'(count), 32'd0);
        chk("stopterm_busy", 32'(busy), 32'd0);
        step(1);
        chk("stopterm_irq", 32'(irq), 32'd0);

        // Period 0 one-shot expires on the first tick.
        issue(OP_START, 0, 1'b0);
        chk("p0_busy", 32'(busy), 32'd1);
        step(1);
        chk("p0_expire", 32'(expire), 32'd1);
        chk("p0_busy_done", 32'(busy), 32'd0);
        chk("p0_count", 32'(count), 32'd0);
        clear_irq();

        // Period 0 periodic expires on every tick.
        issue(OP_START, 0, 1'b1);
        step(1);
        nexp = 0;
        for (int i = 0; i < 4; i++) begin
            nexp += int'(expire);
            step(1);
        end
        chk("p0r_expires", 32'(nexp), 32'd4);
        issue(OP_STOP, 0, 1'b0);
        clear_irq();

        // irq_clr held while irq is set: set wins, then clear takes effect.
        irq_clr = 1'b1;
        issue(OP_START, 1, 1'b1);
        step(2);
        chk("clrset_irq", 32'(irq), 32'd1);
        step(1);
        chk("clrset_cleared", 32'(irq), 32'd0);
        irq_clr = 1'b0;
        issue(OP_STOP, 0, 1'b0);

        // Asynchronous reset mid-run at count 7.
        issue(OP_START, 50, 1'b1);
        wait_count(7);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_irq", 32'(irq), 32'd0);
        chk("arst_expire", 32'(expire), 32'd0);
        chk("arst_ready", 32'(cmd_ready), 32'd1);
        step(1);
        rst = 1'b0;
        step(3);
        chk("arst_after_busy", 32'(busy), 32'd0);
        chk("arst_after_expire", 32'(expire), 32'd0);

`ifdef TIMER_SEQ_PRESCALER_EN
        // Prescaler 2, period 1: ticks every third running clock.
        presc = PRESC_W'(2);
        issue(OP_START, 1, 1'b0);
        chk("psc_ready_low", 32'(cmd_ready), 32'd0);
        n = 0;
        while (!expire && n < 30) begin
            step(1);
            n++;
        end
        chk("psc_expire_delay", 32'(n), 32'd6);
        chk("psc_count", 32'(count), 32'd1);
        clear_irq();
`endif

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_sequencer.md
TIMER_SEQUENCER -- requirements
Module: timer_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning counter and period width in bits.
REQ-002 SHALL have parameter PRESC_W, default 4, meaning prescaler divide-value width.
REQ-003 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 SHALL have port rst, input, 1, an asynchronous active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1, meaning a command is offered.
REQ-006 SHALL have port cmd_ready, output, 1, meaning a command can be accepted.
REQ-007 SHALL have port cmd_op, input, 2, encoded START=0, STOP=1, PAUSE=2, RESUME=3.
REQ-008 SHALL have port cmd_period, input, WIDTH, the terminal count, sampled on START only.
REQ-009 SHALL have port cmd_reload, input, 1, where 1 is periodic and 0 is one-shot, sampled on START only.
REQ-010 SHALL have port presc, input, PRESC_W, the tick divide value, present only with TIMER_SEQ_PRESCALER_EN.
REQ-011 SHALL have port irq_clr, input, 1, which clears irq.
REQ-012 SHALL have port count, output, WIDTH, the current count.
REQ-013 SHALL have port busy, output, 1, high in RUN or PAUSE.
REQ-014 SHALL have port expire, output, 1, a single-cycle terminal-count pulse.
REQ-015 SHALL have port irq, output, 1, a sticky expiry flag.

Function
REQ-016 SHALL accept a command only when cmd_valid and cmd_ready are both high in the same cycle.
REQ-017 SHALL deassert cmd_ready for exactly the one cycle after each accepted command, and hold it high otherwise.
REQ-018 SHALL implement exactly three states, IDLE, RUN and PAUSE, all transitions registered.
REQ-019 SHALL, on START in any state, latch cmd_period and cmd_reload, clear count to 0, enter RUN, and drive busy=1 and count=0 in cycle t+1 for acceptance in cycle t.
REQ-020 SHALL increment count by 1 on each tick in RUN, with the first increment no earlier than t+2.
REQ-021 SHALL, on a RUN tick with count==period, pulse expire for one cycle and set irq.
REQ-022 SHALL, at that terminal tick, load count with 0 and stay in RUN when reload=1, or enter IDLE with count held at period when reload=0.
REQ-023 SHALL, for period=0, expire on every tick with reload=1, or on the first tick only with reload=0.
REQ-024 SHALL, on STOP in any state, enter IDLE, clear count to 0, and not pulse expire.
REQ-025 SHALL, on PAUSE in RUN, enter PAUSE with count frozen; PAUSE in any other state SHALL be ignored.
REQ-026 SHALL, on RESUME in PAUSE, return to RUN with count continuing; RESUME in any other state SHALL be ignored.
REQ-027 SHALL, when a command is accepted in the same cycle as a terminal tick, execute the command and suppress that cycle's expire and irq set.
REQ-028 SHALL, when irq_clr coincides with an irq set, leave irq at 1.
REQ-029 SHALL never exceed period in count, and SHALL perform all count arithmetic modulo 2^WIDTH.

Reset
REQ-030 SHALL, while rst=1, asynchronously force the state to IDLE and drive count=0, busy=0, expire=0, irq=0 and cmd_ready=1.
REQ-031 SHALL, on rst asserted mid-RUN or mid-PAUSE, abort the sequence with no expire pulse and no irq.

Configuration
REQ-032 SHALL, with TIMER_SEQ_PRESCALER_EN defined, latch presc on START and generate one tick every presc+1 clocks in RUN, where presc=0 gives a tick every clock.
REQ-033 SHALL, with TIMER_SEQ_PRESCALER_EN defined, restart the prescaler on START and freeze it in PAUSE.
REQ-034 SHALL, without TIMER_SEQ_PRESCALER_EN, omit the presc port and generate a tick on every RUN clock.

Structure
REQ-035 SHALL place the cmd_op enum, the state enum, and the default WIDTH and PRESC_W constants in the shared package timer_seq_pkg.
REQ-036 SHALL implement the prescaler as the sub-module tick_prescaler, instantiated only under TIMER_SEQ_PRESCALER_EN.

Verification
REQ-037 SHALL cover: START with period=3, reload=0, then expire high exactly at the 4th tick, irq=1, return to IDLE with count=3.
REQ-038 SHALL cover: START with period=2, reload=1, run 9 ticks, then exactly 3 expire pulses and a count sequence of 0,1,2,0,1,2,...
REQ-039 SHALL cover: PAUSE at count=5, 10 idle clocks, then RESUME, with count held at 5 throughout and then continuing at 6.
REQ-040 SHALL cover: STOP issued on the terminal-count cycle, producing no expire, count=0 and IDLE.
REQ-041 SHALL cover: rst asserted mid-RUN at count=7, giving count=0, busy=0 and irq=0 immediately without waiting for clk.
REQ-042 SHALL cover: with the macro, presc=2 and period=1, giving an expire 6 clocks after the first tick window and cmd_ready low one cycle after each command.
